n64_vbus_demux: RTL and testbench

Front-end video stage: samples the N64 7-bit multiplexed video bus and reassembles one 25-bit pixel word per four VCLK cycles. Each word is `{sync nibble, R, G, B}`, presented with a one-cycle low `nVDSYNC_o` strobe. Its output drives the gamma stage input `video_data_i`/`nVDSYNC` directly. It also classifies the incoming stream as PAL/NTSC and progressive/interlaced from line counts.

---
 rtl/n64_vbus_demux_pkg.sv | 39 +++
 rtl/n64_vbus_demux_if.sv | 36 +++
 rtl/n64_vbus_demux_vmode_detect.sv | 64 ++++++
 rtl/n64_vbus_demux.sv | 133 +++++++++++++
 tb/tb_n64_vbus_demux.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/n64_vbus_demux_pkg.sv
// Shared constants, state encoding and pixel word layout for the N64 video bus demux.
// Optional build macro: VDEMUX_SYNCCHK_EN (resync error pulse and idle watchdog).
package n64_vbus_demux_pkg;

   localparam int unsigned COLOR_W_DEF         = 7;
   localparam int unsigned SYNC_W_DEF          = 4;
   localparam int unsigned VDATA_W_DEF         = SYNC_W_DEF + 3 * COLOR_W_DEF;
   localparam int unsigned PAL_LINE_THRESH_DEF = 288;
   localparam int unsigned LINE_CNT_W          = 10;
   localparam int unsigned WDOG_W              = 4;

   // Bit positions inside the sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
   localparam int unsigned SY_NCSYNC = 0;
   localparam int unsigned SY_NHSYNC = 1;
   localparam int unsigned SY_NCLAMP = 2;
   localparam int unsigned SY_NVSYNC = 3;

   // Slice offsets of the 25-bit pixel word
   localparam int unsigned BL_LSB = 0;
   localparam int unsigned GR_LSB = COLOR_W_DEF;
   localparam int unsigned RE_LSB = 2 * COLOR_W_DEF;
   localparam int unsigned SY_LSB = 3 * COLOR_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_R    = 2'd1,
      ST_G    = 2'd2,
      ST_B    = 2'd3
   } vdemux_state_e;

   // Default-width pixel word as presented on vdata_o
   typedef struct packed {
      logic [SYNC_W_DEF-1:0]  sy;
      logic [COLOR_W_DEF-1:0] re;
      logic [COLOR_W_DEF-1:0] gr;
      logic [COLOR_W_DEF-1:0] bl;
   } vdata_t;

endpackage

// File: rtl/n64_vbus_demux_if.sv
// Video bus bundle: multiplexed N64 input side and reassembled pixel output side.
// Optional build macro: VDEMUX_SYNCCHK_EN adds sync_err_o.
interface n64_vbus_demux_if #(
   parameter int unsigned COLOR_W = 7,
   parameter int unsigned SYNC_W  = 4
);
   localparam int unsigned VDATA_W = SYNC_W + 3 * COLOR_W;

   logic               nDSYNC;
   logic [COLOR_W-1:0] D_i;
   logic [VDATA_W-1:0] vdata_o;
   logic               nVDSYNC_o;
   logic               vmode_o;
   logic               n64_480i_o;
`ifdef VDEMUX_SYNCCHK_EN
   logic               sync_err_o;

   modport slave (
      input  nDSYNC, D_i,
      output vdata_o, nVDSYNC_o, vmode_o, n64_480i_o, sync_err_o
   );
   modport master (
      output nDSYNC, D_i,
      input  vdata_o, nVDSYNC_o, vmode_o, n64_480i_o, sync_err_o
   );
`else
   modport slave (
      input  nDSYNC, D_i,
      output vdata_o, nVDSYNC_o, vmode_o, n64_480i_o
   );
   modport master (
      output nDSYNC, D_i,
      input  vdata_o, nVDSYNC_o, vmode_o, n64_480i_o
   );
`endif
endinterface

// File: rtl/n64_vbus_demux_vmode_detect.sv
// n64_vmode_detect: counts lines per field from emitted sync nibbles and
// classifies the stream as PAL/NTSC and progressive/interlaced.
module n64_vmode_detect
   import n64_vbus_demux_pkg::*;
#(
   parameter int unsigned PAL_LINE_THRESH = PAL_LINE_THRESH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic emit,
   input  logic nhsync,
   input  logic nvsync,
   input  logic line_clr,
   output logic vmode,
   output logic interlaced
);

   localparam logic [LINE_CNT_W-1:0] THRESH  = LINE_CNT_W'(PAL_LINE_THRESH);
   localparam logic [LINE_CNT_W-1:0] CNT_MAX = '1;

   logic                  prev_hs_q;
   logic                  prev_vs_q;
   logic [LINE_CNT_W-1:0] count_q;
   logic [LINE_CNT_W-1:0] prev_count_q;
   logic                  vmode_q;
   logic                  interlaced_q;
   logic                  hs_fall_c;
   logic                  vs_fall_c;

   // Edges are judged only between consecutive emitted words
   assign hs_fall_c = emit & prev_hs_q & ~nhsync;
   assign vs_fall_c = emit & prev_vs_q & ~nvsync;

   // Previous emitted sync bits, line counter and field-end classification
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_hs_q    <= 1'b1;
         prev_vs_q    <= 1'b1;
         count_q      <= '0;
         prev_count_q <= '0;
         vmode_q      <= 1'b0;
         interlaced_q <= 1'b0;
      end else begin
         if (emit) begin
            prev_hs_q <= nhsync;
            prev_vs_q <= nvsync;
         end
         if (vs_fall_c) begin
            vmode_q      <= (count_q >= THRESH);
            interlaced_q <= (count_q[0] != prev_count_q[0]);
            prev_count_q <= count_q;
            count_q      <= '0;
         end else if (line_clr) begin
            count_q <= '0;
         end else if (hs_fall_c && (count_q != CNT_MAX)) begin
            count_q <= count_q + LINE_CNT_W'(1);
         end
      end
   end

   assign vmode      = vmode_q;
   assign interlaced = interlaced_q;

endmodule

// File: rtl/n64_vbus_demux.sv
// n64_vbus_demux: reassembles {sync, R, G, B} pixel words from the N64 7-bit
// multiplexed video bus, one word per four VCLK cycles with an nVDSYNC_o strobe.
// Optional build macro: VDEMUX_SYNCCHK_EN (sync_err_o pulse on resync, idle watchdog).
module n64_vbus_demux
   import n64_vbus_demux_pkg::*;
#(
   parameter int unsigned COLOR_W         = COLOR_W_DEF,
   parameter int unsigned SYNC_W          = SYNC_W_DEF,
   parameter int unsigned PAL_LINE_THRESH = PAL_LINE_THRESH_DEF
) (
   input  logic            VCLK,
   input  logic            RST,
   n64_vbus_demux_if.slave bus
);

   localparam int unsigned VDATA_W = SYNC_W + 3 * COLOR_W;

   vdemux_state_e      state_q;
   vdemux_state_e      state_d;
   logic [SYNC_W-1:0]  sync_q;
   logic [COLOR_W-1:0] r_q;
   logic [COLOR_W-1:0] g_q;
   logic [VDATA_W-1:0] vdata_q;
   logic               nvdsync_q;
   logic               sync_ld_c;
   logic               r_ld_c;
   logic               g_ld_c;
   logic               emit_c;
   logic               line_clr_c;
   logic               vmode;
   logic               interlaced;

   // State register
   always_ff @(posedge VCLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state: nDSYNC low always restarts at S_R, so an early sync resyncs
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!bus.nDSYNC) state_d = ST_R;
         ST_R:    state_d = bus.nDSYNC ? ST_G    : ST_R;
         ST_G:    state_d = bus.nDSYNC ? ST_B    : ST_R;
         ST_B:    state_d = bus.nDSYNC ? ST_IDLE : ST_R;
         default: state_d = ST_IDLE;
      endcase
   end

   // Per-phase capture enables
   always_comb begin
      sync_ld_c = 1'b0;
      r_ld_c    = 1'b0;
      g_ld_c    = 1'b0;
      emit_c    = 1'b0;
      if (!bus.nDSYNC) begin
         sync_ld_c = 1'b1;
      end else begin
         case (state_q)
            ST_R:    r_ld_c = 1'b1;
            ST_G:    g_ld_c = 1'b1;
            ST_B:    emit_c = 1'b1;
            default: ;
         endcase
      end
   end

   // Phase capture registers and pixel word output; partial pixels never reach vdata
   always_ff @(posedge VCLK) begin
      if (RST) begin
         sync_q    <= '0;
         r_q       <= '0;
         g_q       <= '0;
         vdata_q   <= '0;
         nvdsync_q <= 1'b1;
      end else begin
         if (sync_ld_c) sync_q  <= bus.D_i[SYNC_W-1:0];
         if (r_ld_c)    r_q     <= bus.D_i;
         if (g_ld_c)    g_q     <= bus.D_i;
         if (emit_c)    vdata_q <= {sync_q, r_q, g_q, bus.D_i};
         nvdsync_q <= ~emit_c | line_clr_c;
      end
   end

`ifdef VDEMUX_SYNCCHK_EN
   localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

   logic [WDOG_W-1:0] wdog_q;
   logic              sync_err_q;
   logic              resync_c;

   assign resync_c = (state_q != ST_IDLE) & ~bus.nDSYNC;

   // Saturating count of consecutive IDLE cycles; a full count means the stream stalled
   always_ff @(posedge VCLK) begin
      if (RST)                    wdog_q <= '0;
      else if (state_q != ST_IDLE) wdog_q <= '0;
      else if (wdog_q != WDOG_MAX) wdog_q <= wdog_q + WDOG_W'(1);
   end

   assign line_clr_c = (wdog_q == WDOG_MAX);

   // One-cycle pulse for each dropped partial pixel
   always_ff @(posedge VCLK) begin
      if (RST) sync_err_q <= 1'b0;
      else     sync_err_q <= resync_c;
   end

   assign bus.sync_err_o = sync_err_q;
`else
   assign line_clr_c = 1'b0;
`endif

   n64_vmode_detect #(
      .PAL_LINE_THRESH (PAL_LINE_THRESH)
   ) u_vmode_detect (
      .clk        (VCLK),
      .rst        (RST),
      .emit       (emit_c),
      .nhsync     (sync_q[SY_NHSYNC]),
      .nvsync     (sync_q[SY_NVSYNC]),
      .line_clr   (line_clr_c),
      .vmode      (vmode),
      .interlaced (interlaced)
   );

   assign bus.vdata_o    = vdata_q;
   assign bus.nVDSYNC_o  = nvdsync_q;
   assign bus.vmode_o    = vmode;
   assign bus.n64_480i_o = interlaced;

endmodule

// File: tb/tb_n64_vbus_demux.sv
// Directed bench for n64_vbus_demux. Inputs change on the falling edge; outputs
// are read right after that, so they reflect the preceding rising edge.
module tb_n64_vbus_demux;
   import n64_vbus_demux_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [24:0] last_word = '0;

   always #10 clk = ~clk;

   n64_vbus_demux_if #(.COLOR_W(7), .SYNC_W(4)) bus ();

   n64_vbus_demux dut (
      .VCLK (clk),
      .RST  (rst),
      .bus  (bus)
   );

   initial begin
      #10000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic step(input logic nd, input logic [6:0] d);
      @(negedge clk);
      bus.nDSYNC = nd;
      bus.D_i    = d;
   endtask

   task automatic send_word(input logic [3:0] sy, input logic [6:0] r, input logic [6:0] g,
                            input logic [6:0] b);
      step(1'b0, {3'b000, sy});
      step(1'b1, r);
      step(1'b1, g);
      step(1'b1, b);
   endtask

   // One line: nHSYNC high word then nHSYNC low word (one 1->0 transition)
   task automatic send_line();
      send_word(4'hF, 7'h10, 7'h20, 7'h30);
      send_word(4'hD, 7'h01, 7'h02, 7'h03);
   endtask

   task automatic test_reset();
      send_word(4'hF, 7'h11, 7'h22, 7'h33);
      step(1'b1, 7'h00);
      if (bus.vdata_o !== 25'h0) begin bad++; $display("FAIL rst_vdata: got %h want %h", bus.vdata_o, 25'h0); end
      total++;
      if (bus.nVDSYNC_o !== 1'b1) begin bad++; $display("FAIL rst_strobe: got %b want 1", bus.nVDSYNC_o); end
      total++;
      if (bus.vmode_o !== 1'b0) begin bad++; $display("FAIL rst_vmode: got %b want 0", bus.vmode_o); end
      total++;
      if (bus.n64_480i_o !== 1'b0) begin bad++; $display("FAIL rst_480i: got %b want 0", bus.n64_480i_o); end
      total++;
`ifdef VDEMUX_SYNCCHK_EN
      if (bus.sync_err_o !== 1'b0) begin bad++; $display("FAIL rst_sync_err: got %b want 0", bus.sync_err_o); end
      total++;
`endif
      rst = 1'b0;
      step(1'b1, 7'h00);
      if (bus.nVDSYNC_o !== 1'b1) begin bad++; $display("FAIL rst_idle_strobe: got %b want 1", bus.nVDSYNC_o); end
      total++;
   endtask

   task automatic test_stream();
      vdata_t      px [4];
      logic        nd;
      logic [6:0]  d;
      logic        exp_nvd;
      logic [24:0] exp_w;
      int          strobes;
      px[0] = '{4'hF, 7'h11, 7'h22, 7'h33};
      px[1] = '{4'hF, 7'h7F, 7'h00, 7'h55};
      px[2] = '{4'hF, 7'h2A, 7'h15, 7'h40};
      px[3] = '{4'hE, 7'h01, 7'h7E, 7'h3C};
      strobes = 0;
      for (int i = 0; i < 17; i++) begin
         nd = 1'b1;
         d  = 7'h00;
         if (i < 16) begin
            case (i % 4)
               0:       begin nd = 1'b0; d = {3'b000, px[i/4].sy}; end
               1:       d = px[i/4].re;
               2:       d = px[i/4].gr;
               default: d = px[i/4].bl;
            endcase
         end
         step(nd, d);
         exp_nvd = !((i >= 4) && ((i % 4) == 0));
         exp_w   = (i >= 4) ? px[i/4 - 1] : 25'h0;
         if (bus.nVDSYNC_o !== exp_nvd) begin bad++; $display("FAIL stream_strobe[%0d]: got %b want %b", i, bus.nVDSYNC_o, exp_nvd); end
         total++;
         if (bus.vdata_o !== exp_w) begin bad++; $display("FAIL stream_vdata[%0d]: got %h want %h", i, bus.vdata_o, exp_w); end
         total++;
         if (bus.nVDSYNC_o === 1'b0) strobes++;
      end
      if (strobes !== 4) begin bad++; $display("FAIL stream_count: got %0d want 4", strobes); end
      total++;
      last_word = px[3];
   endtask

   task automatic test_resync();
      logic        nds [8];
      logic [6:0]  ds  [8];
      vdata_t      nw;
      logic        exp_nvd;
      logic [24:0] exp_w;
      int          errs;
      nds = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ds  = '{7'h0F, 7'h10, 7'h0E, 7'h21, 7'h32, 7'h43, 7'h00, 7'h00};
      nw  = '{4'hE, 7'h21, 7'h32, 7'h43};
      errs = 0;
      for (int i = 0; i < 8; i++) begin
         step(nds[i], ds[i]);
         exp_nvd = (i != 6);
         exp_w   = (i >= 6) ? nw : last_word;
         if (bus.nVDSYNC_o !== exp_nvd) begin bad++; $display("FAIL resync_strobe[%0d]: got %b want %b", i, bus.nVDSYNC_o, exp_nvd); end
         total++;
         if (bus.vdata_o !== exp_w) begin bad++; $display("FAIL resync_vdata[%0d]: got %h want %h", i, bus.vdata_o, exp_w); end
         total++;
`ifdef VDEMUX_SYNCCHK_EN
         if (bus.sync_err_o !== (i == 3)) begin bad++; $display("FAIL resync_err[%0d]: got %b want %b", i, bus.sync_err_o, (i == 3)); end
         total++;
         if (bus.sync_err_o === 1'b1) errs++;
`endif
      end
`ifdef VDEMUX_SYNCCHK_EN
      if (errs !== 1) begin bad++; $display("FAIL resync_err_count: got %0d want 1", errs); end
      total++;
`endif
      last_word = nw;
   endtask

   task automatic test_modes();
      int     lens [7];
      logic   ev   [7];
      logic   ei   [7];
      logic   old_v;
      vdata_t vs_w;
      lens = '{262, 263, 263, 287, 288, 312, 312};
      ev   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      ei   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vs_w = '{4'h7, 7'h05, 7'h06, 7'h07};
      // Field alignment: an empty field end, then re-arm nVSYNC
      send_word(4'h7, 7'h01, 7'h02, 7'h03);
      send_word(4'hF, 7'h01, 7'h02, 7'h03);
      old_v = 1'b0;
      for (int f = 0; f < 7; f++) begin
         repeat (lens[f]) send_line();
         step(1'b0, 7'h07);
         step(1'b1, 7'h05);
         step(1'b1, 7'h06);
         step(1'b1, 7'h07);
         if (bus.vmode_o !== old_v) begin bad++; $display("FAIL mode_hold[%0d]: got %b want %b", f, bus.vmode_o, old_v); end
         total++;
         step(1'b0, 7'h0F);
         if (bus.nVDSYNC_o !== 1'b0) begin bad++; $display("FAIL field_strobe[%0d]: got %b want 0", f, bus.nVDSYNC_o); end
         total++;
         if (bus.vdata_o !== vs_w) begin bad++; $display("FAIL field_vdata[%0d]: got %h want %h", f, bus.vdata_o, vs_w); end
         total++;
         if (bus.vmode_o !== ev[f]) begin bad++; $display("FAIL vmode[%0d] lines=%0d: got %b want %b", f, lens[f], bus.vmode_o, ev[f]); end
         total++;
         if (bus.n64_480i_o !== ei[f]) begin bad++; $display("FAIL n64_480i[%0d] lines=%0d: got %b want %b", f, lens[f], bus.n64_480i_o, ei[f]); end
         total++;
         step(1'b1, 7'h00);
         step(1'b1, 7'h00);
         step(1'b1, 7'h00);
         old_v = ev[f];
      end
   endtask

   task automatic test_rst_mid();
      vdata_t nw;
      nw = '{4'hC, 7'h41, 7'h52, 7'h63};
      step(1'b0, 7'h0A);
      step(1'b1, 7'h11);
      step(1'b1, 7'h22);
      @(negedge clk);
      rst = 1'b1;
      bus.nDSYNC = 1'b1;
      bus.D_i    = 7'h33;
      @(negedge clk);
      rst = 1'b0;
      bus.nDSYNC = 1'b1;
      bus.D_i    = 7'h00;
      if (bus.vdata_o !== 25'h0) begin bad++; $display("FAIL rstmid_vdata: got %h want %h", bus.vdata_o, 25'h0); end
      total++;
      if (bus.nVDSYNC_o !== 1'b1) begin bad++; $display("FAIL rstmid_strobe: got %b want 1", bus.nVDSYNC_o); end
      total++;
      if (bus.vmode_o !== 1'b0) begin bad++; $display("FAIL rstmid_vmode: got %b want 0", bus.vmode_o); end
      total++;
      if (bus.n64_480i_o !== 1'b0) begin bad++; $display("FAIL rstmid_480i: got %b want 0", bus.n64_480i_o); end
      total++;
      step(1'b1, 7'h00);
      if (bus.nVDSYNC_o !== 1'b1) begin bad++; $display("FAIL rstmid_late_strobe: got %b want 1", bus.nVDSYNC_o); end
      total++;
      send_word(nw.sy, nw.re, nw.gr, nw.bl);
      step(1'b1, 7'h00);
      if (bus.nVDSYNC_o !== 1'b0) begin bad++; $display("FAIL rstmid_resume_strobe: got %b want 0", bus.nVDSYNC_o); end
      total++;
      if (bus.vdata_o !== nw) begin bad++; $display("FAIL rstmid_resume_vdata: got %h want %h", bus.vdata_o, nw); end
      total++;
   endtask

`ifdef VDEMUX_SYNCCHK_EN
   task automatic test_watchdog();
      send_word(4'h7, 7'h01, 7'h02, 7'h03);
      send_word(4'hF, 7'h01, 7'h02, 7'h03);
      repeat (300) send_line();
      send_word(4'h7, 7'h05, 7'h06, 7'h07);
      step(1'b0, 7'h0F);
      if (bus.vmode_o !== 1'b1) begin bad++; $display("FAIL wd_setup_vmode: got %b want 1", bus.vmode_o); end
      total++;
      step(1'b1, 7'h00);
      step(1'b1, 7'h00);
      step(1'b1, 7'h00);
      repeat (300) send_line();
      step(1'b1, 7'h00);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 7'h00);
         if (bus.nVDSYNC_o !== 1'b1) begin bad++; $display("FAIL wd_idle_strobe[%0d]: got %b want 1", i, bus.nVDSYNC_o); end
         total++;
         if (bus.sync_err_o !== 1'b0) begin bad++; $display("FAIL wd_idle_err[%0d]: got %b want 0", i, bus.sync_err_o); end
         total++;
      end
      send_word(4'h7, 7'h05, 7'h06, 7'h07);
      step(1'b1, 7'h00);
      if (bus.nVDSYNC_o !== 1'b0) begin bad++; $display("FAIL wd_field_strobe: got %b want 0", bus.nVDSYNC_o); end
      total++;
      if (bus.vmode_o !== 1'b0) begin bad++; $display("FAIL wd_line_clear: got vmode %b want 0", bus.vmode_o); end
      total++;
   endtask
`endif

   initial begin
      bus.nDSYNC = 1'b1;
      bus.D_i    = 7'h00;
      rst        = 1'b1;
      test_reset();
      test_stream();
      test_resync();
      test_modes();
      test_rst_mid();
`ifdef VDEMUX_SYNCCHK_EN
      test_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
